fwd_src_pipe: RTL and testbench
===============================

# fwd_src_pipe

EX/MEM and MEM/WB pipeline register pair for the 5-stage MIPS core: the producer side of the forwarding protocol. It captures each instruction's destination tag, RegWrite flag and result at the EX→MEM and MEM→WB boundaries. It publishes the EX/MEM.Rd/RegWrite and MEM/WB.Rd/RegWrite tags and data consumed by the forwarding unit and the register file write port, and raises the load-use stall that forwarding cannot cover.

## Interface
Parameters:
- DW, 32, datapath width
- AW, 5, register address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous: invalidate the instruction entering EX/MEM this cycle
- ex_valid_i  in  1  ID/EX holds a real instruction (0 = bubble)
- ex_rd_i  in  AW  ID/EX destination register (already muxed Rt/Rd)
- ex_regwrite_i  in  1  ID/EX.RegWrite
- ex_memtoreg_i  in  1  ID/EX.MemtoReg (load)
- ex_result_i  in  DW  ALU result / store address from EX
- mem_rdata_i  in  DW  data memory read data for the instruction in EX/MEM (combinational, same cycle)
- id_rs_i, id_rt_i  in  AW  IF/ID source registers
- id_uses_rt_i  in  1  IF/ID instruction reads Rt as a source
- exmem_rd_o  out  AW  EX/MEM.Rd
- exmem_regwrite_o  out  1  EX/MEM.RegWrite
- exmem_result_o  out  DW  EX/MEM ALU result (ForwardA/B = 10 source)
- memwb_rd_o  out  AW  MEM/WB.Rd, also register file write address
- memwb_regwrite_o  out  1  MEM/WB.RegWrite, also register file write enable
- memwb_wdata_o  out  DW  write-back data (ForwardA/B = 01 source)
- load_use_stall_o  out  1  freeze PC and IF/ID, insert bubble into ID/EX
- retire_cnt_o  out  32  retired register writes (see Configuration)

## Operation
- EX/MEM capture, each rising edge: valid_q ← ex_valid_i & ~flush_i. rd_q ← ex_rd_i. result_q ← ex_result_i. memtoreg_q ← ex_memtoreg_i.
- EX/MEM RegWrite is qualified on capture: regwrite_q ← ex_valid_i & ~flush_i & ex_regwrite_i & (ex_rd_i ≠ 0). Writes to $0 never leave EX/MEM as RegWrite=1.
- MEM/WB capture, each rising edge: rd ← EX/MEM rd. regwrite ← EX/MEM regwrite. wdata ← memtoreg_q ? mem_rdata_i : result_q.
- When EX/MEM holds a bubble (valid 0), MEM/WB still captures it, with regwrite 0.
- Outputs are driven directly from the registers. There is no combinational path from ex_* to exmem_* or memwb_*.
- load_use_stall_o (combinational) = ex_valid_i & ex_memtoreg_i & ex_regwrite_i & (ex_rd_i ≠ 0) & ((ex_rd_i == id_rs_i) | (id_uses_rt_i & (ex_rd_i == id_rt_i))).
- This block does not itself hold the pipeline. Upstream presents ex_valid_i = 0 on the cycle after a stall, so the stall lasts exactly one cycle per load-use pair.
- flush_i and load_use_stall_o may both be high in one cycle: the flush applies to EX/MEM capture, and the stall output is still reported.
- No saturation or wrap handling on datapath. The counter wraps modulo 2^32.

## Timing
- Reset (rst_i high, asynchronous): all valid/regwrite/memtoreg flags are 0 and every rd, result and wdata register is 0. All outputs are 0 during reset. load_use_stall_o depends only on inputs.
- Reset asserted mid-operation clears both stages immediately. Instructions in flight are lost and no register file write occurs.
- An instruction in EX at cycle n appears on exmem_* at n+1 and on memwb_* at n+2. The register file write happens at the n+3 edge (write-back latency 2).
- mem_rdata_i is sampled at the edge that ends the instruction's MEM cycle.
- Throughput: one instruction per cycle, no internal stalls.

## Configuration
- RETIRE_CNT_EN defined: a 32-bit counter increments on each rising edge where MEM/WB regwrite is 1 (one count per retired write). It resets to 0 and drives retire_cnt_o.
- RETIRE_CNT_EN undefined: no counter is built and retire_cnt_o is tied to 0.

## Test plan
- Reset: rst_i pulsed high mid-clock with a valid add in flight → all outputs are 0 asynchronously, and no memwb_regwrite_o pulse follows release.
- ALU chain: add $3 with result 0x0000_0010 presented in EX at cycle 0 → exmem_rd_o=3, regwrite=1, result 0x10 at cycle 1. memwb_rd_o=3, memwb_wdata_o=0x10 at cycle 2. retire_cnt_o=1 after that cycle with RETIRE_CNT_EN.
- $0 squash: ex_rd_i=0, ex_regwrite_i=1, ex_result_i=0xDEADBEEF → exmem_regwrite_o=0 and memwb_regwrite_o=0. With RETIRE_CNT_EN the counter does not advance.
- Load path: lw $5 (ex_memtoreg_i=1, result 0x100), mem_rdata_i=0xCAFE_F00D in the MEM cycle → memwb_wdata_o=0xCAFEF00D, not 0x100.
- Load-use: ex lw $5 with id_rs_i=5 → stall=1. With id_rt_i=5 and id_uses_rt_i=0 → stall=0. With id_uses_rt_i=1 → stall=1. Bubble next cycle → stall=0.
- Flush: flush_i=1 with a valid add $7 in EX → exmem_regwrite_o=0 next cycle, and memwb_regwrite_o=0 the cycle after.

Source files
------------

// File: rtl/fwd_src_pipe.sv
// ============================================================================
// Module   : fwd_src_pipe
// Purpose  : EX/MEM and MEM/WB pipeline registers that source the forwarding
//            tags/data, the register file write port and the load-use stall.
//            Optional build macro RETIRE_CNT_EN adds a retired-write counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_src_pipe #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          ex_valid_i,
    input  logic [AW-1:0] ex_rd_i,
    input  logic          ex_regwrite_i,
    input  logic          ex_memtoreg_i,
    input  logic [DW-1:0] ex_result_i,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic          id_uses_rt_i,
    output logic [AW-1:0] exmem_rd_o,
    output logic          exmem_regwrite_o,
    output logic [DW-1:0] exmem_result_o,
    output logic [AW-1:0] memwb_rd_o,
    output logic          memwb_regwrite_o,
    output logic [DW-1:0] memwb_wdata_o,
    output logic          load_use_stall_o,
    output logic [31:0]   retire_cnt_o
);

    localparam logic [AW-1:0] c_REG_ZERO = '0;

    // EX/MEM stage
    logic          exmem_valid_q,    exmem_valid_d;
    logic [AW-1:0] exmem_rd_q,       exmem_rd_d;
    logic          exmem_regwrite_q, exmem_regwrite_d;
    logic          exmem_memtoreg_q, exmem_memtoreg_d;
    logic [DW-1:0] exmem_result_q,   exmem_result_d;

    // MEM/WB stage
    logic [AW-1:0] memwb_rd_q,       memwb_rd_d;
    logic          memwb_regwrite_q, memwb_regwrite_d;
    logic [DW-1:0] memwb_wdata_q,    memwb_wdata_d;

    logic          w_ex_live;
    logic          w_ex_writes_gpr;

    assign w_ex_live       = ex_valid_i & ~flush_i;
    assign w_ex_writes_gpr = ex_regwrite_i & (ex_rd_i != c_REG_ZERO);

    always_comb begin
        exmem_valid_d    = w_ex_live;
        exmem_rd_d       = ex_rd_i;
        exmem_result_d   = ex_result_i;
        exmem_memtoreg_d = ex_memtoreg_i;
        // $0 writes are dropped here so nothing downstream has to re-check Rd
        exmem_regwrite_d = w_ex_live & w_ex_writes_gpr;

        memwb_rd_d       = exmem_rd_q;
        memwb_regwrite_d = exmem_valid_q & exmem_regwrite_q;
        memwb_wdata_d    = exmem_memtoreg_q ? mem_rdata_i : exmem_result_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exmem_valid_q    <= 1'b0;
            exmem_rd_q       <= '0;
            exmem_regwrite_q <= 1'b0;
            exmem_memtoreg_q <= 1'b0;
            exmem_result_q   <= '0;
            memwb_rd_q       <= '0;
            memwb_regwrite_q <= 1'b0;
            memwb_wdata_q    <= '0;
        end else begin
            exmem_valid_q    <= exmem_valid_d;
            exmem_rd_q       <= exmem_rd_d;
            exmem_regwrite_q <= exmem_regwrite_d;
            exmem_memtoreg_q <= exmem_memtoreg_d;
            exmem_result_q   <= exmem_result_d;
            memwb_rd_q       <= memwb_rd_d;
            memwb_regwrite_q <= memwb_regwrite_d;
            memwb_wdata_q    <= memwb_wdata_d;
        end
    end

    assign exmem_rd_o       = exmem_rd_q;
    assign exmem_regwrite_o = exmem_regwrite_q;
    assign exmem_result_o   = exmem_result_q;
    assign memwb_rd_o       = memwb_rd_q;
    assign memwb_regwrite_o = memwb_regwrite_q;
    assign memwb_wdata_o    = memwb_wdata_q;

    // A load in EX cannot be forwarded to ID in time; only its consumer stalls.
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = (ex_rd_i == id_rs_i);
    assign w_rt_hit = id_uses_rt_i & (ex_rd_i == id_rt_i);

    assign load_use_stall_o = ex_valid_i & ex_memtoreg_i & w_ex_writes_gpr
                            & (w_rs_hit | w_rt_hit);

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (memwb_regwrite_q) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt_o = retire_cnt_q;
`else
    assign retire_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_src_pipe.sv
// ============================================================================
// Module   : tb_fwd_src_pipe
// Purpose  : Self-checking bench for fwd_src_pipe: directed vector table,
//            reset corner sequences and a randomized run against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_src_pipe;

    localparam int c_DW    = 32;
    localparam int c_AW    = 5;
    localparam int c_NRAND = 400;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              ex_valid_i;
    logic [c_AW-1:0]   ex_rd_i;
    logic              ex_regwrite_i;
    logic              ex_memtoreg_i;
    logic [c_DW-1:0]   ex_result_i;
    logic [c_DW-1:0]   mem_rdata_i;
    logic [c_AW-1:0]   id_rs_i;
    logic [c_AW-1:0]   id_rt_i;
    logic              id_uses_rt_i;
    logic [c_AW-1:0]   exmem_rd_o;
    logic              exmem_regwrite_o;
    logic [c_DW-1:0]   exmem_result_o;
    logic [c_AW-1:0]   memwb_rd_o;
    logic              memwb_regwrite_o;
    logic [c_DW-1:0]   memwb_wdata_o;
    logic              load_use_stall_o;
    logic [31:0]       retire_cnt_o;

    fwd_src_pipe #(.DW(c_DW), .AW(c_AW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .ex_valid_i       (ex_valid_i),
        .ex_rd_i          (ex_rd_i),
        .ex_regwrite_i    (ex_regwrite_i),
        .ex_memtoreg_i    (ex_memtoreg_i),
        .ex_result_i      (ex_result_i),
        .mem_rdata_i      (mem_rdata_i),
        .id_rs_i          (id_rs_i),
        .id_rt_i          (id_rt_i),
        .id_uses_rt_i     (id_uses_rt_i),
        .exmem_rd_o       (exmem_rd_o),
        .exmem_regwrite_o (exmem_regwrite_o),
        .exmem_result_o   (exmem_result_o),
        .memwb_rd_o       (memwb_rd_o),
        .memwb_regwrite_o (memwb_regwrite_o),
        .memwb_wdata_o    (memwb_wdata_o),
        .load_use_stall_o (load_use_stall_o),
        .retire_cnt_o     (retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One directed row: inputs for one cycle, stall expected that cycle,
    // exmem_* expected after the edge, memwb_* expected after the edge.
    typedef struct {
        logic        flush, valid, rw, mtr, uses_rt;
        logic [4:0]  rd, rs, rt;
        logic [31:0] res, rdata;
        logic        e_stall, e_ex_rw, e_wb_rw;
        logic [4:0]  e_ex_rd, e_wb_rd;
        logic [31:0] e_ex_res, e_wb_data;
    } vec_t;

    vec_t vt[10];

    function automatic vec_t mk(
        input logic f, v, rw, mtr, input logic [4:0] rd, input logic [31:0] res,
        input logic [31:0] rdata, input logic [4:0] rs, rt, input logic urt,
        input logic es, input logic eexrw, input logic [4:0] eexrd, input logic [31:0] eexres,
        input logic ewbrw, input logic [4:0] ewbrd, input logic [31:0] ewbd);
        vec_t x;
        x.flush = f; x.valid = v; x.rw = rw; x.mtr = mtr; x.rd = rd; x.res = res;
        x.rdata = rdata; x.rs = rs; x.rt = rt; x.uses_rt = urt; x.e_stall = es;
        x.e_ex_rw = eexrw; x.e_ex_rd = eexrd; x.e_ex_res = eexres;
        x.e_wb_rw = ewbrw; x.e_wb_rd = ewbrd; x.e_wb_data = ewbd;
        return x;
    endfunction

    task automatic drive(input logic f, v, rw, mtr, input logic [4:0] rd,
                         input logic [31:0] res, rdata, input logic [4:0] rs, rt,
                         input logic urt);
        flush_i = f; ex_valid_i = v; ex_regwrite_i = rw; ex_memtoreg_i = mtr;
        ex_rd_i = rd; ex_result_i = res; mem_rdata_i = rdata;
        id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = urt;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        bubble();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Randomized reference: instructions recorded per cycle; stage contents
    // are simply the instruction one and two cycles back.
    typedef struct {
        logic        f, v, rw, mtr;
        logic [4:0]  rd;
        logic [31:0] res, rdata;
    } ins_t;

    ins_t hist[c_NRAND+1];

    function automatic logic writes(input ins_t x);
        return x.v && !x.f && x.rw && (x.rd != 5'd0);
    endfunction

    initial begin
        logic        exp_stall;
        logic [31:0] exp_cnt;
        logic [4:0]  rs, rt;
        logic        urt;
        ins_t        cur, old;

        rst_i = 1'b1;
        bubble();
        #2;
        chk("reset_exmem_rw", {31'd0, exmem_regwrite_o}, 32'd0);
        chk("reset_exmem_rd", {27'd0, exmem_rd_o}, 32'd0);
        chk("reset_exmem_res", exmem_result_o, 32'd0);
        chk("reset_memwb_rw", {31'd0, memwb_regwrite_o}, 32'd0);
        chk("reset_memwb_rd", {27'd0, memwb_rd_o}, 32'd0);
        chk("reset_memwb_data", memwb_wdata_o, 32'd0);
        chk("reset_cnt", retire_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        //          f  v  rw mtr rd  res           rdata         rs  rt  urt st exrw exrd exres        wbrw wbrd wbdata
        vt[0] = mk(0, 1, 1, 0, 3, 32'h10,       32'h0,        0,  0,  0,  0, 1, 3, 32'h10,       0, 0, 32'h0);
        vt[1] = mk(0, 1, 1, 0, 0, 32'hDEADBEEF, 32'h1111,     0,  0,  0,  0, 0, 0, 32'hDEADBEEF, 1, 3, 32'h10);
        vt[2] = mk(0, 1, 1, 1, 5, 32'h100,      32'h2222,     5,  0,  0,  1, 1, 5, 32'h100,      0, 0, 32'hDEADBEEF);
        vt[3] = mk(0, 0, 0, 0, 0, 32'h0,        32'hCAFEF00D, 5,  0,  0,  0, 0, 0, 32'h0,        1, 5, 32'hCAFEF00D);
        vt[4] = mk(0, 1, 1, 1, 5, 32'h200,      32'h3333,     1,  5,  0,  0, 1, 5, 32'h200,      0, 0, 32'h0);
        vt[5] = mk(0, 1, 1, 1, 6, 32'h300,      32'h4444,     0,  6,  1,  1, 1, 6, 32'h300,      1, 5, 32'h4444);
        vt[6] = mk(1, 1, 1, 0, 7, 32'h77,       32'h5555,     7,  0,  0,  0, 0, 7, 32'h77,       1, 6, 32'h5555);
        vt[7] = mk(1, 1, 1, 1, 8, 32'h88,       32'h6666,     8,  0,  0,  1, 0, 8, 32'h88,       0, 7, 32'h77);
        vt[8] = mk(0, 0, 0, 0, 0, 32'h0,        32'h9999,     8,  0,  0,  0, 0, 0, 32'h0,        0, 8, 32'h9999);
        vt[9] = mk(0, 1, 1, 1, 0, 32'hA0,       32'h0,        0,  0,  0,  0, 0, 0, 32'hA0,       0, 0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            drive(vt[i].flush, vt[i].valid, vt[i].rw, vt[i].mtr, vt[i].rd, vt[i].res,
                  vt[i].rdata, vt[i].rs, vt[i].rt, vt[i].uses_rt);
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, load_use_stall_o}, {31'd0, vt[i].e_stall});
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_exmem_rw", i), {31'd0, exmem_regwrite_o}, {31'd0, vt[i].e_ex_rw});
            chk($sformatf("v%0d_exmem_rd", i), {27'd0, exmem_rd_o}, {27'd0, vt[i].e_ex_rd});
            chk($sformatf("v%0d_exmem_res", i), exmem_result_o, vt[i].e_ex_res);
            chk($sformatf("v%0d_memwb_rw", i), {31'd0, memwb_regwrite_o}, {31'd0, vt[i].e_wb_rw});
            chk($sformatf("v%0d_memwb_rd", i), {27'd0, memwb_rd_o}, {27'd0, vt[i].e_wb_rd});
            chk($sformatf("v%0d_memwb_data", i), memwb_wdata_o, vt[i].e_wb_data);
        end

        // Asynchronous reset with a valid add $3 sitting in EX/MEM.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h10, 32'h0, 5'd0, 5'd0, 1'b0);
        @(posedge clk_i);
        #1;
        chk("pre_rst_exmem_rw", {31'd0, exmem_regwrite_o}, 32'd1);
        bubble();
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_exmem_rw", {31'd0, exmem_regwrite_o}, 32'd0);
        chk("async_rst_exmem_rd", {27'd0, exmem_rd_o}, 32'd0);
        chk("async_rst_exmem_res", exmem_result_o, 32'd0);
        chk("async_rst_memwb_rw", {31'd0, memwb_regwrite_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("post_rst_memwb_rw%0d", k), {31'd0, memwb_regwrite_o}, 32'd0);
            chk($sformatf("post_rst_cnt%0d", k), retire_cnt_o, 32'd0);
        end

        // Randomized run against the history model.
        do_reset();
        hist[0] = '{f: 1'b0, v: 1'b0, rw: 1'b0, mtr: 1'b0, rd: 5'd0, res: 32'd0, rdata: 32'd0};
        exp_cnt = 32'd0;
        for (int c = 1; c <= c_NRAND; c++) begin
            @(negedge clk_i);
            cur.f     = ($urandom_range(0, 7) == 0);
            cur.v     = ($urandom_range(0, 5) != 0);
            cur.rw    = ($urandom_range(0, 4) != 0);
            cur.mtr   = $urandom_range(0, 1) == 1;
            cur.rd    = 5'($urandom_range(0, 3));
            cur.res   = $urandom;
            cur.rdata = $urandom;
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            urt = $urandom_range(0, 1) == 1;
            hist[c] = cur;
            drive(cur.f, cur.v, cur.rw, cur.mtr, cur.rd, cur.res, cur.rdata, rs, rt, urt);
            exp_stall = cur.v && cur.mtr && cur.rw && cur.rd != 5'd0
                        && (cur.rd == rs || (urt && cur.rd == rt));
            #1;
            chk("rnd_stall", {31'd0, load_use_stall_o}, {31'd0, exp_stall});
`ifdef RETIRE_CNT_EN
            // The instruction now in MEM/WB is the one entered two cycles ago.
            if (c >= 3 && writes(hist[c-2])) exp_cnt = exp_cnt + 32'd1;
`endif
            @(posedge clk_i);
            #1;
            old = hist[c-1];
            chk("rnd_exmem_rw", {31'd0, exmem_regwrite_o}, {31'd0, writes(cur)});
            chk("rnd_exmem_rd", {27'd0, exmem_rd_o}, {27'd0, cur.rd});
            chk("rnd_exmem_res", exmem_result_o, cur.res);
            chk("rnd_memwb_rw", {31'd0, memwb_regwrite_o}, {31'd0, (c >= 2) && writes(old)});
            chk("rnd_memwb_rd", {27'd0, memwb_rd_o}, {27'd0, old.rd});
            chk("rnd_memwb_data", memwb_wdata_o, old.mtr ? cur.rdata : old.res);
            chk("rnd_cnt", retire_cnt_o, exp_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
